vc_dest_arbiter: RTL and testbench

- Schedules transfers from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the transmission-layer datapath.
- Grants at most one VC per cycle. VC0 has weighted priority; a starvation guard protects VC1.
- Honours per-destination almost-full backpressure and is gated by the main controller's active state.
- Sits between the VC FIFO outputs and the D FIFO push inputs.

---
 rtl/vc_dest_arbiter_pkg.sv | 19 +
 rtl/vc_dest_arbiter_if.sv | 35 +++
 rtl/vc_dest_arbiter_wcnt.sv | 32 +++
 rtl/vc_dest_arbiter.sv | 123 ++++++++++++
 tb/tb_vc_dest_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/vc_dest_arbiter_pkg.sv
// vc_dest_arbiter shared types and constants.
// FSM state encoding, destination-select index and default weight.
package vc_dest_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_VC0_WEIGHT = 3;
  localparam int WCNT_W         = 4;

  // Destination select lives one below the MSB of the word.
  function automatic int dsel_bit(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// VC FIFO head / D FIFO push bundle for vc_dest_arbiter.
// master = arbiter side, slave = FIFO side.
interface vc_dest_arbiter_if #(
  parameter int DATA_WIDTH = 6
);

  logic [DATA_WIDTH-1:0] vc0_data;
  logic                  vc0_empty;
  logic                  vc0_pop;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  vc1_empty;
  logic                  vc1_pop;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] d_data;

  modport master (
    input  vc0_data, vc0_empty,
    input  vc1_data, vc1_empty,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop,
    output d0_push, d1_push, d_data
  );

  modport slave (
    output vc0_data, vc0_empty,
    output vc1_data, vc1_empty,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop,
    input  d0_push, d1_push, d_data
  );

endinterface

// File: rtl/vc_dest_arbiter_wcnt.sv
// vc_weight_counter: counts VC0 wins over an eligible VC1.
// Saturates at WEIGHT; force_vc1 flags VC1's turn.
module vc_weight_counter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int WEIGHT = DEF_VC0_WEIGHT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_vc1
);

  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(WEIGHT);

  logic [WCNT_W-1:0] wcnt;

  // Clear on VC1 grant, count VC0 wins, never pass WMAX.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (inc && wcnt != WMAX) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign force_vc1 = (wcnt == WMAX);

endmodule

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: weighted VC0/VC1 scheduler into D0/D1.
// VC_DEST_ARBITER_STATS_EN adds grant/stall counters.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VC0_WEIGHT = DEF_VC0_WEIGHT
) (
  input  logic clk,
  input  logic reset,
  input  logic active_in,
  output logic busy,
`ifdef VC_DEST_ARBITER_STATS_EN
  output logic [7:0] grant_cnt_vc0,
  output logic [7:0] grant_cnt_vc1,
  output logic [7:0] stall_cnt,
`endif
  vc_dest_arbiter_if.master bus
);

  localparam int SEL = dsel_bit(DATA_WIDTH);

  state_t state;
  state_t state_nx;

  logic run_en;
  logic vc0_dst;
  logic vc1_dst;
  logic vc0_elig;
  logic vc1_elig;
  logic gnt0;
  logic gnt1;
  logic gnt_any;
  logic gnt_dst;
  logic force_vc1;
  logic [DATA_WIDTH-1:0] gnt_data;

  logic                  d0_push_q;
  logic                  d1_push_q;
  logic [DATA_WIDTH-1:0] d_data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state follows active_in.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (active_in)  state_nx = RUN;
      RUN:  if (!active_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign run_en = busy && active_in;

  assign vc0_dst = bus.vc0_data[SEL];
  assign vc1_dst = bus.vc1_data[SEL];

  // Eligibility and grant selection.
  always_comb begin
    vc0_elig = run_en && !bus.vc0_empty &&
      !(vc0_dst ? bus.d1_almost_full : bus.d0_almost_full);
    vc1_elig = run_en && !bus.vc1_empty &&
      !(vc1_dst ? bus.d1_almost_full : bus.d0_almost_full);
    gnt1     = vc1_elig && (!vc0_elig || force_vc1);
    gnt0     = vc0_elig && !gnt1;
    gnt_any  = gnt0 || gnt1;
    gnt_dst  = gnt1 ? vc1_dst : vc0_dst;
    gnt_data = gnt1 ? bus.vc1_data : bus.vc0_data;
  end

  vc_weight_counter #(
    .WEIGHT(VC0_WEIGHT)
  ) u_wcnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (gnt0 && vc1_elig),
    .clr      (gnt1),
    .force_vc1(force_vc1)
  );

  assign bus.vc0_pop = gnt0 && reset;
  assign bus.vc1_pop = gnt1 && reset;

  // One-cycle push of the granted head word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      d0_push_q <= gnt_any && !gnt_dst;
      d1_push_q <= gnt_any && gnt_dst;
      if (gnt_any) d_data_q <= gnt_data;
    end
  end

  assign bus.d0_push = d0_push_q;
  assign bus.d1_push = d1_push_q;
  assign bus.d_data  = d_data_q;

`ifdef VC_DEST_ARBITER_STATS_EN
  // Wrapping grant counters and RUN-cycle stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt_vc0 <= '0;
      grant_cnt_vc1 <= '0;
      stall_cnt     <= '0;
    end else begin
      if (gnt0) grant_cnt_vc0 <= grant_cnt_vc0 + 1'b1;
      if (gnt1) grant_cnt_vc1 <= grant_cnt_vc1 + 1'b1;
      if (busy && !gnt_any && (!bus.vc0_empty || !bus.vc1_empty))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed self-checking bench for vc_dest_arbiter.
// Stats checks run when VC_DEST_ARBITER_STATS_EN is defined.
module tb_vc_dest_arbiter;

  logic clk;
  logic reset;
  logic active_in;
  logic busy;
`ifdef VC_DEST_ARBITER_STATS_EN
  logic [7:0] grant_cnt_vc0;
  logic [7:0] grant_cnt_vc1;
  logic [7:0] stall_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  vc_dest_arbiter_if #(.DATA_WIDTH(6)) bus ();

  vc_dest_arbiter #(
    .DATA_WIDTH(6),
    .VC0_WEIGHT(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .active_in    (active_in),
    .busy         (busy),
`ifdef VC_DEST_ARBITER_STATS_EN
    .grant_cnt_vc0(grant_cnt_vc0),
    .grant_cnt_vc1(grant_cnt_vc1),
    .stall_cnt    (stall_cnt),
`endif
    .bus          (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset              = 1'b0;
    active_in          = 1'b0;
    bus.vc0_data       = '0;
    bus.vc1_data       = '0;
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    tick();
    tick();
    check("rst_d0_push", 8'(bus.d0_push), 8'd0);
    check("rst_d1_push", 8'(bus.d1_push), 8'd0);
    check("rst_d_data", 8'(bus.d_data), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    bus.vc0_empty = 1'b0;
    #1;
    check("rst_pop0", 8'(bus.vc0_pop), 8'd0);
    bus.vc0_empty = 1'b1;

    reset     = 1'b1;
    active_in = 1'b1;
    tick();
    check("run_busy", 8'(busy), 8'd1);

    // Single VC0 word to D0.
    bus.vc0_data  = 6'b000101;
    bus.vc0_empty = 1'b0;
    #1;
    check("t1_pop0", 8'(bus.vc0_pop), 8'd1);
    check("t1_pop1", 8'(bus.vc1_pop), 8'd0);
    tick();
    bus.vc0_empty = 1'b1;
    check("t1_d0_push", 8'(bus.d0_push), 8'd1);
    check("t1_d1_push", 8'(bus.d1_push), 8'd0);
    check("t1_d_data", 8'(bus.d_data), 8'h05);
    #1;
    check("t1_pop0_off", 8'(bus.vc0_pop), 8'd0);
    tick();
    check("t1_d0_idle", 8'(bus.d0_push), 8'd0);
    check("t1_hold", 8'(bus.d_data), 8'h05);

    // Single VC1 word routed to D1.
    bus.vc1_data  = 6'b110110;
    bus.vc1_empty = 1'b0;
    #1;
    check("t2_pop1", 8'(bus.vc1_pop), 8'd1);
    check("t2_pop0", 8'(bus.vc0_pop), 8'd0);
    tick();
    bus.vc1_empty = 1'b1;
    check("t2_d1_push", 8'(bus.d1_push), 8'd1);
    check("t2_d0_push", 8'(bus.d0_push), 8'd0);
    check("t2_d_data", 8'(bus.d_data), 8'h36);

    // Weighted pattern VC0,VC0,VC0,VC1 repeating.
    bus.vc0_data  = 6'b000001;
    bus.vc1_data  = 6'b010010;
    bus.vc0_empty = 1'b0;
    bus.vc1_empty = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic v1;
      v1 = ((k % 4) == 3);
      #1;
      check($sformatf("t3_pop0_%0d", k), 8'(bus.vc0_pop), 8'(!v1));
      check($sformatf("t3_pop1_%0d", k), 8'(bus.vc1_pop), 8'(v1));
      tick();
      check($sformatf("t3_d1_%0d", k), 8'(bus.d1_push), 8'(v1));
      check($sformatf("t3_data_%0d", k), 8'(bus.d_data),
            v1 ? 8'h12 : 8'h01);
    end
    bus.vc0_empty = 1'b1;
    bus.vc1_empty = 1'b1;

    // D0 backpressure: only VC1 flows until the flag drops.
    bus.d0_almost_full = 1'b1;
    bus.vc0_empty      = 1'b0;
    bus.vc1_empty      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t4_pop0_%0d", k), 8'(bus.vc0_pop), 8'd0);
      check($sformatf("t4_pop1_%0d", k), 8'(bus.vc1_pop), 8'd1);
      tick();
      check($sformatf("t4_d1_%0d", k), 8'(bus.d1_push), 8'd1);
      check($sformatf("t4_d0_%0d", k), 8'(bus.d0_push), 8'd0);
    end
    bus.d0_almost_full = 1'b0;
    #1;
    check("t4_resume_pop0", 8'(bus.vc0_pop), 8'd1);
    check("t4_resume_pop1", 8'(bus.vc1_pop), 8'd0);
    tick();
    check("t4_resume_d0", 8'(bus.d0_push), 8'd1);
    check("t4_resume_data", 8'(bus.d_data), 8'h01);

    // Both heads target a full D1: nothing granted.
    bus.vc0_data       = 6'b010001;
    bus.d1_almost_full = 1'b1;
    #1;
    check("t4b_pop0", 8'(bus.vc0_pop), 8'd0);
    check("t4b_pop1", 8'(bus.vc1_pop), 8'd0);
    tick();
    check("t4b_d0", 8'(bus.d0_push), 8'd0);
    check("t4b_d1", 8'(bus.d1_push), 8'd0);
    check("t4b_hold", 8'(bus.d_data), 8'h01);
    bus.d1_almost_full = 1'b0;
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;

    // active_in drops one cycle after a grant.
    bus.vc0_data  = 6'b000101;
    bus.vc0_empty = 1'b0;
    #1;
    check("t5_pop0", 8'(bus.vc0_pop), 8'd1);
    tick();
    active_in = 1'b0;
    #1;
    check("t5_push_out", 8'(bus.d0_push), 8'd1);
    check("t5_no_pop", 8'(bus.vc0_pop), 8'd0);
    tick();
    check("t5_busy", 8'(busy), 8'd0);
    check("t5_d0_off", 8'(bus.d0_push), 8'd0);
    check("t5_idle_pop", 8'(bus.vc0_pop), 8'd0);

    // Reset mid-stream drops the pending push.
    active_in = 1'b1;
    tick();
    check("t6_busy", 8'(busy), 8'd1);
    check("t6_pop0", 8'(bus.vc0_pop), 8'd1);
    reset = 1'b0;
    #1;
    check("t6_pop_forced", 8'(bus.vc0_pop), 8'd0);
    tick();
    check("t6_d0", 8'(bus.d0_push), 8'd0);
    check("t6_data", 8'(bus.d_data), 8'd0);
    check("t6_busy_off", 8'(busy), 8'd0);
    bus.vc0_empty = 1'b1;
    reset         = 1'b1;
    tick();

`ifdef VC_DEST_ARBITER_STATS_EN
    // 300 VC0 grants wrap to 44; then two stalled cycles.
    tick();
    bus.vc0_empty = 1'b0;
    repeat (300) tick();
    bus.vc0_empty = 1'b1;
    tick();
    check("st_vc0", grant_cnt_vc0, 8'd44);
    check("st_vc1", grant_cnt_vc1, 8'd0);
    check("st_stall0", stall_cnt, 8'd0);
    bus.d0_almost_full = 1'b1;
    bus.vc0_empty      = 1'b0;
    repeat (2) tick();
    bus.vc0_empty      = 1'b1;
    bus.d0_almost_full = 1'b0;
    tick();
    check("st_stall2", stall_cnt, 8'd2);
    check("st_vc0_hold", grant_cnt_vc0, 8'd44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
